// File: rtl/mp4_icache_responder.sv
// mp4_icache_responder
// Direct-mapped, read-only instruction cache on the responder side of the
// CPU fetch port. Hits are answered combinationally in the request cycle.
// A miss fetches a whole 32-byte line from the line-wide memory path,
// installs it, and then answers the request on the lookup after a bubble.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | lookup; answer hits, latch line address and start a miss
//   ST_FETCH | pmem_read held with the latched line address until pmem_resp
//   ST_FILL  | one bubble after the line is written; lookup resumes after it
//
// Tag and data arrays are plain registers with no reset; only the valid bits
// carry reset state, so a set is never trusted until it has been filled.

module mp4_icache_responder #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inst_read,
    input  logic [31:0]  inst_addr,
    output logic         inst_resp,
    output logic [31:0]  inst_rdata,
    output logic         pmem_read,
    output logic [31:0]  pmem_addr,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int SETS   = 2 ** S_INDEX;
    localparam int TAG_LO = S_OFFSET + S_INDEX;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [31:0]        hit_count_q, hit_count_d;
    logic [31:0]        miss_count_q, miss_count_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [S_TAG-1:0]   tag_q  [SETS];
    logic [255:0]       line_q [SETS];

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [2:0]         req_word;
    logic [S_TAG-1:0]   fill_tag;
    logic [S_INDEX-1:0] fill_idx;
    logic               lookup;
    logic               hit;
    logic               miss_start;
    logic               fill_en;
    logic [255:0]       req_line;
    logic [31:0]        req_data;
    logic [1:0]         unused_addr_bits;

    // Split the request and the latched miss address into tag/index/word
    always_comb begin
        req_tag          = inst_addr[31:TAG_LO];
        req_idx          = inst_addr[TAG_LO-1:S_OFFSET];
        req_word         = inst_addr[4:2];
        fill_tag         = miss_addr_q[31:TAG_LO];
        fill_idx         = miss_addr_q[TAG_LO-1:S_OFFSET];
        unused_addr_bits = inst_addr[1:0];
    end

    // Lookup: hit detection and word select from the indexed line
    always_comb begin
        lookup     = (state_q == ST_IDLE) && inst_read && !reset;
        hit        = lookup && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        miss_start = lookup && !hit;
        fill_en    = (state_q == ST_FETCH) && pmem_resp && !reset;
        req_line   = line_q[req_idx];
        req_data   = req_line[{req_word, 5'b00000} +: 32];
    end

    // Sequencing: idle lookup, line fetch, fill bubble
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_start) begin
                    miss_addr_d = {inst_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pmem_resp) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid bits: a set becomes valid only when its line lands during a fetch
    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Performance counters; each miss is counted once, when it is detected
    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit};
        miss_count_d = miss_count_q + {31'd0, miss_start};
    end

    // Control state, valid bits and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            miss_addr_q  <= 32'd0;
            valid_q      <= '0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tag and line storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            line_q[fill_idx] <= pmem_rdata;
        end
    end

    // Port outputs; the response path is zero whenever no hit is being served
    always_comb begin
        inst_resp  = hit;
        inst_rdata = hit ? req_data : 32'd0;
        pmem_read  = (state_q == ST_FETCH);
        pmem_addr  = (state_q == ST_FETCH) ? miss_addr_q : 32'd0;
        hit_count  = hit_count_q;
        miss_count = miss_count_q;
    end

endmodule

// File: tb/tb_mp4_icache_responder.sv
// Directed bench for mp4_icache_responder: cold miss, same-line hits,
// conflict misses, redirect during a fetch, reset during a fetch, and idle.

module tb_mp4_icache_responder;

    logic         clk;
    logic         reset;
    logic         inst_read;
    logic [31:0]  inst_addr;
    logic         inst_resp;
    logic [31:0]  inst_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    mp4_icache_responder dut (
        .clk        (clk),
        .reset      (reset),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .pmem_read  (pmem_read),
        .pmem_addr  (pmem_addr),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
        return l;
    endfunction

    // Called in the first FETCH cycle; returns in the IDLE cycle after FILL
    task automatic serve_fetch(input string tag, input int lat,
                               input logic [31:0] base, input logic [31:0] addr);
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_pmem_read"}, {31'd0, pmem_read}, 32'd1);
            chk({tag, "_pmem_addr"}, pmem_addr, addr);
            chk({tag, "_resp_fetch"}, {31'd0, inst_resp}, 32'd0);
            if (k == lat - 1) begin
                pmem_rdata = make_line(base);
                pmem_resp  = 1'b1;
            end
            tick();
        end
        pmem_resp = 1'b0;
        chk({tag, "_fill_pmem_read"}, {31'd0, pmem_read}, 32'd0);
        chk({tag, "_fill_resp"}, {31'd0, inst_resp}, 32'd0);
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = 32'd0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
        chk("rst_pmem_addr", pmem_addr, 32'd0);
        chk("rst_resp", {31'd0, inst_resp}, 32'd0);
        chk("rst_rdata", inst_rdata, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        reset = 1'b0;
        tick();

        // Cold miss on 0x60, memory latency 5
        inst_read = 1'b1;
        inst_addr = 32'h60;
        #1;
        chk("cold_miss_resp", {31'd0, inst_resp}, 32'd0);
        tick();
        chk("cold_misses", miss_count, 32'd1);
        serve_fetch("cold", 5, 32'hA000_0000, 32'h60);
        chk("cold_resp", {31'd0, inst_resp}, 32'd1);
        chk("cold_rdata", inst_rdata, 32'hA000_0000);

        // Same-line hits
        tick();
        inst_addr = 32'h64;
        #1;
        chk("hit1_count", hit_count, 32'd1);
        chk("hit1_resp", {31'd0, inst_resp}, 32'd1);
        chk("hit1_rdata", inst_rdata, 32'hA000_0001);
        chk("hit1_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        inst_addr = 32'h7C;
        #1;
        chk("hit2_resp", {31'd0, inst_resp}, 32'd1);
        chk("hit2_rdata", inst_rdata, 32'hA000_0007);
        chk("hit2_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        inst_read = 1'b0;
        #1;
        chk("hits_after3", hit_count, 32'd3);
        chk("misses_after3", miss_count, 32'd1);
        chk("noread_resp", {31'd0, inst_resp}, 32'd0);
        chk("noread_rdata", inst_rdata, 32'd0);

        // Conflict: 0x160 shares index 3 with 0x60
        tick();
        inst_read = 1'b1;
        inst_addr = 32'h160;
        #1;
        chk("conf_miss_resp", {31'd0, inst_resp}, 32'd0);
        tick();
        chk("conf_misses", miss_count, 32'd2);
        serve_fetch("conf", 3, 32'hB000_0000, 32'h160);
        chk("conf_resp", {31'd0, inst_resp}, 32'd1);
        chk("conf_rdata", inst_rdata, 32'hB000_0000);
        tick();
        inst_addr = 32'h60;
        #1;
        chk("evict_miss_resp", {31'd0, inst_resp}, 32'd0);
        tick();
        chk("evict_misses", miss_count, 32'd3);
        serve_fetch("evict", 2, 32'hA000_0000, 32'h60);
        chk("evict_resp", {31'd0, inst_resp}, 32'd1);
        chk("evict_rdata", inst_rdata, 32'hA000_0000);

        // Redirect from 0x200 to resident 0x60 during the fetch
        tick();
        inst_addr = 32'h200;
        #1;
        chk("redir_miss_resp", {31'd0, inst_resp}, 32'd0);
        chk("redir_hits", hit_count, 32'd5);
        tick();
        chk("redir_misses", miss_count, 32'd4);
        chk("redir_pmem_addr1", pmem_addr, 32'h200);
        tick();
        chk("redir_pmem_read2", {31'd0, pmem_read}, 32'd1);
        tick();
        inst_addr = 32'h60;
        #1;
        chk("redir_pmem_read3", {31'd0, pmem_read}, 32'd1);
        chk("redir_pmem_addr3", pmem_addr, 32'h200);
        chk("redir_resp3", {31'd0, inst_resp}, 32'd0);
        pmem_rdata = make_line(32'hC000_0000);
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("redir_fill_resp", {31'd0, inst_resp}, 32'd0);
        chk("redir_fill_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        chk("redir_hit_resp", {31'd0, inst_resp}, 32'd1);
        chk("redir_hit_rdata", inst_rdata, 32'hA000_0000);
        tick();
        inst_addr = 32'h208;
        #1;
        chk("redir_later_resp", {31'd0, inst_resp}, 32'd1);
        chk("redir_later_rdata", inst_rdata, 32'hC000_0002);
        chk("redir_later_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        inst_read = 1'b0;
        #1;
        chk("redir_end_misses", miss_count, 32'd4);
        chk("redir_end_hits", hit_count, 32'd7);

        // Reset during the fetch for 0x400; late pmem_resp must be ignored
        tick();
        inst_read = 1'b1;
        inst_addr = 32'h400;
        #1;
        chk("rmid_miss_resp", {31'd0, inst_resp}, 32'd0);
        tick();
        chk("rmid_pmem_read", {31'd0, pmem_read}, 32'd1);
        chk("rmid_pmem_addr", pmem_addr, 32'h400);
        tick();
        reset     = 1'b1;
        inst_read = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rmid_pmem_read_after", {31'd0, pmem_read}, 32'd0);
        chk("rmid_hits", hit_count, 32'd0);
        chk("rmid_misses", miss_count, 32'd0);
        tick();
        tick();
        pmem_rdata = make_line(32'hD000_0000);
        pmem_resp  = 1'b1;
        #1;
        chk("rmid_stray_pmem", {31'd0, pmem_read}, 32'd0);
        tick();
        pmem_resp = 1'b0;
        inst_read = 1'b1;
        inst_addr = 32'h400;
        #1;
        chk("rmid_relook_resp", {31'd0, inst_resp}, 32'd0);
        chk("rmid_relook_misses", miss_count, 32'd0);
        tick();
        chk("rmid_remiss_count", miss_count, 32'd1);
        serve_fetch("rmid", 1, 32'hD000_0000, 32'h400);
        chk("rmid_resp", {31'd0, inst_resp}, 32'd1);
        chk("rmid_rdata", inst_rdata, 32'hD000_0000);
        tick();
        inst_read = 1'b0;
        #1;
        chk("rmid_end_hits", hit_count, 32'd1);

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_resp", {31'd0, inst_resp}, 32'd0);
            chk("idle_pmem_read", {31'd0, pmem_read}, 32'd0);
        end
        chk("idle_hits", hit_count, 32'd1);
        chk("idle_misses", miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp4_icache_responder.md
Name: mp4_icache_responder

Overview:
- Direct-mapped, read-only instruction cache on the responder side of the CPU instruction port (inst_read/inst_addr -> inst_resp/inst_rdata).
- Sits between the mp4 pipeline fetch stage and the line-wide physical memory path (arbiter / cacheline adaptor).
- Serves hits in the request cycle.
- On a miss, fetches a full 256-bit line, fills it, then serves the request.
- Exposes hit and miss counters for performance measurement.

Parameters:
- S_INDEX, 3, index bits; number of sets = 2**S_INDEX (default 8).
- S_OFFSET, 5, line offset bits; line = 32 bytes = 8 words. Fixed; other values unsupported.
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (default 24).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_read  in  1  CPU fetch request
- inst_addr  in  32  fetch byte address; bits [1:0] ignored
- inst_resp  out  1  one-cycle response; inst_rdata valid when high
- inst_rdata  out  32  instruction word
- pmem_read  out  1  line read request to memory side
- pmem_addr  out  32  line-aligned address; bits [4:0] = 0
- pmem_rdata  in  256  returned line; word w at bits [32w+31:32w]
- pmem_resp  in  1  line valid, one-cycle pulse
- hit_count  out  32  number of hit responses
- miss_count  out  32  number of misses started

Behaviour:
- Address split:
  - tag = inst_addr[31:S_OFFSET+S_INDEX]
  - idx = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET]
  - word = inst_addr[4:2]
- Storage per set: valid bit, tag, 256-bit line. Registers only, no SRAM macro.
- Reset (synchronous):
  - All valid bits = 0; state = IDLE.
  - pmem_read = 0, pmem_addr = 0, inst_resp = 0, inst_rdata = 0.
  - hit_count = 0, miss_count = 0.
  - Tag and data contents are don't-care.
- States: IDLE, FETCH, FILL.
- IDLE:
  - hit = inst_read & valid[idx] & tag match.
  - On hit: inst_resp = 1 combinationally in the same cycle; inst_rdata = line[idx] word `word`; hit_count += 1 at the clock edge.
  - On inst_read without hit: latch line address {inst_addr[31:5],5'b0} into miss_addr; miss_count += 1; next state = FETCH.
  - When inst_read = 0: inst_resp = 0 and inst_rdata = 0.
- FETCH:
  - pmem_read = 1 and pmem_addr = miss_addr, both held stable until pmem_resp.
  - inst_resp = 0.
  - On pmem_resp: write pmem_rdata into the set selected by miss_addr; set valid; write tag from miss_addr; next state = FILL.
- FILL:
  - One bubble cycle; pmem_read = 0, inst_resp = 0; next state = IDLE.
  - The CPU request is then re-evaluated as a lookup and hits.
- Miss latency = memory latency (cycles from pmem_read rise to pmem_resp) + 2 cycles.
- Handshake: the CPU holds inst_read and inst_addr stable until inst_resp.
- CPU changes inst_addr during FETCH (e.g. branch redirect):
  - The fill completes for the latched miss_addr only.
  - The new address is looked up in IDLE after FILL.
  - No response is given for the abandoned address.
- inst_read dropping during FETCH: the fill still completes, with no response.
- pmem_resp is ignored outside FETCH.
- Reset asserted mid-FETCH:
  - Abort immediately; pmem_read = 0 next cycle.
  - A pmem_resp arriving afterwards is ignored; no set becomes valid.
- A conflict miss (same idx, different tag) overwrites the line; there is no writeback because the cache is read-only.
- Counters are 32-bit and wrap modulo 2^32. The miss count increments exactly once per miss, independent of fetch duration.

Test Plan:
- Cold miss: reset; inst_read = 1, inst_addr = 0x60 with memory returning a line whose word w = 0xA0000000+w after 5 cycles.
  - Required: pmem_read high with pmem_addr = 0x60 for 5 cycles; FILL bubble.
  - Next cycle: inst_resp = 1 and inst_rdata = 0xA0000000.
  - Counters: miss_count = 1, hit_count = 1.
- Same-line hits: after the fill, read 0x64 then 0x7C.
  - Required: inst_resp in the request cycle with rdata 0xA0000001 then 0xA0000007.
  - pmem_read stays 0; hit_count = 3.
- Conflict: read 0x160 (same idx 3, different tag) with line word w = 0xB0000000+w.
  - Required: miss, pmem_addr = 0x160, resp rdata = 0xB0000000.
  - A subsequent read of 0x60 misses again; miss_count = 3.
- Redirect mid-fetch: miss on 0x200; after 2 cycles change inst_addr to 0x60 (resident).
  - Required: fill completes for 0x200; 0x60 hits in the IDLE cycle after FILL.
  - A later read of 0x200 hits with no new pmem_read.
- Reset mid-fetch: assert reset during FETCH for 0x400; pulse pmem_resp two cycles after reset deasserts.
  - Required: pmem_read = 0 after reset; counters = 0.
  - A read of 0x400 misses and pmem_read reasserts.
- Idle: inst_read = 0 for 20 cycles.
  - Required: inst_resp = 0, pmem_read = 0, counters unchanged.
